barrel_shift_pipe: RTL
======================

Name: barrel_shift_pipe

Overview:
Parametrised, pipelined successor to the 8-bit combinational left/right barrel shifter. Shifts or rotates a WIDTH-bit word by 0..WIDTH-1 positions in either direction, in logical, arithmetic or rotate mode. It uses one registered stage per shift-amount bit, with a valid/ready handshake on both sides. It sits between a producer (ALU operand path / bench driver) and a consumer that may stall.

Parameters:
WIDTH, 8, data width in bits; power of two, minimum 2.
SHW, $clog2(WIDTH), shift-amount width and pipeline depth (derived; not overridden).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  input word/command valid.
in_ready  output  1  block accepts input this cycle.
in_x  input  WIDTH  data word.
in_shift  input  SHW  shift amount, unsigned.
in_lr  input  1  direction: 0 = left, 1 = right.
in_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_y  output  WIDTH  shifted result.
out_zero  output  1  present only with BARREL_SHIFT_ZERO_FLAG_EN; see Optional Feature.

Behaviour:
- Reset: synchronous and active-high. While rst=1 at a clock edge, all stage valids clear, out_valid=0, out_y=0, out_zero=0. in_ready=0 while rst is high. All in-flight items are discarded; no partial result emerges after reset.
- Transfer rules: input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
- Pipeline: SHW stages. Stage k (k=0..SHW-1) applies a shift of 2^k when bit k of the carried shift amount is set, then registers the data, remaining shift bits, lr, mode and valid.
- Latency: exactly SHW cycles from input transfer to out_valid with no stalls (3 for WIDTH=8). Throughput is one item per cycle.
- Stall: stage k loads when it is empty or when stage k+1 loads / the output transfers. in_ready = ~stage0_valid | stage0_advances, computed combinationally from out_ready through the chain. No bubbles are inserted and no items are dropped or duplicated.
- While out_valid=1 and out_ready=0, out_y and out_zero hold stable.
- Left shift: logical and arithmetic modes fill with 0. Rotate mode wraps the MSBs into the LSBs.
- Right shift: logical mode fills with 0. Arithmetic mode fills with the original in_x[WIDTH-1], carried through the pipeline. Rotate mode wraps the LSBs into the MSBs.
- Shift of 0 passes the data unchanged in every mode.
- Mode 11 produces results identical to mode 00.
- Simultaneous input and output transfers in the same cycle are legal, and a full pipeline sustains flow.
- in_x, in_shift, in_lr and in_mode are sampled only on an input transfer; they are don't-care otherwise.

Optional Feature:
Macro BARREL_SHIFT_ZERO_FLAG_EN.
- Defined: port out_zero exists. It is registered alongside out_y, equals (out_y == 0), resets to 0, and holds during a stall.
- Undefined: the port and its logic are absent; all other behaviour and latency are identical.

Decomposition:
- Package barrel_shift_pkg holds the mode constants (MODE_LOGICAL=2'b00, MODE_ARITH=2'b01, MODE_ROTATE=2'b10) and the direction constants (DIR_LEFT=0, DIR_RIGHT=1).
- Sub-module barrel_shift_stage, parametrised by WIDTH, SHW and stage index K, contains one conditional 2^K shift/rotate plus its pipeline register and valid/stall logic. barrel_shift_pipe generates SHW instances and the output flag.

Test Plan:
- WIDTH=8, in_x=8'hB3, in_shift=3, out_ready=1:
  - left logical -> 8'h98
  - right logical -> 8'h16
  - right arithmetic -> 8'hF6
  - left rotate -> 8'h9D
  - right rotate -> 8'h76
  - Each appears exactly 3 cycles after acceptance.
- Sweep: in_x=8'hB3 with in_shift 0..7 in all directions and modes, issued back to back -> 48 results in order, one per cycle, matching the reference model. Shift 0 gives 8'hB3.
- Stall: stream 5 items, hold out_ready=0 for 6 cycles -> in_ready drops once 3 items are buffered, out_y stays stable, and all 5 results emerge in order after release with none lost.
- Reset mid-stream: assert rst for 1 cycle with 3 items in flight -> out_valid=0 and out_y=0 the next cycle, no stale result afterwards, and a new item's latency is 3.
- Zero flag (macro defined): in_x=8'h00, shift 3, left logical -> out_y=8'h00, out_zero=1. in_x=8'hFF, shift 5, right arithmetic -> out_y=8'hFF, out_zero=0.
- Generic: WIDTH=32, in_x=32'h8000_0001, shift 31, right arithmetic -> 32'hFFFF_FFFF after 5 cycles. Left rotate by 1 -> 32'h0000_0003.

Source files
------------

// File: rtl/barrel_shift_pkg.sv
// Shared constants for the pipelined barrel shifter: shift modes and directions.
package barrel_shift_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_LOGICAL = 2'b00;
  localparam logic [MODE_W-1:0] MODE_ARITH   = 2'b01;
  localparam logic [MODE_W-1:0] MODE_ROTATE  = 2'b10;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/barrel_shift_stage.sv
// One barrel-shifter pipeline stage: conditional shift/rotate by 2^K followed by
// a skid-free pipeline register that loads when empty or when downstream advances.
module barrel_shift_stage
  import barrel_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH),
  parameter int unsigned K     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [WIDTH-1:0]  i_x,
  input  logic [SHW-1:0]    i_shift,
  input  logic              i_lr,
  input  logic [MODE_W-1:0] i_mode,
  input  logic              i_sign,
  input  logic              i_next_load,
  output logic              o_load_c,
  output logic [WIDTH-1:0]  o_data_c,
  output logic              o_valid,
  output logic [WIDTH-1:0]  o_x,
  output logic [SHW-1:0]    o_shift,
  output logic              o_lr,
  output logic [MODE_W-1:0] o_mode,
  output logic              o_sign
);

  localparam int unsigned S = 1 << K;

  logic              r_valid;
  logic [WIDTH-1:0]  r_x;
  logic [SHW-1:0]    r_shift;
  logic              r_lr;
  logic [MODE_W-1:0] r_mode;
  logic              r_sign;

  logic              w_fill;
  logic [WIDTH-1:0]  w_shl;
  logic [WIDTH-1:0]  w_shr;
  logic [WIDTH-1:0]  w_rotl;
  logic [WIDTH-1:0]  w_rotr;
  logic [WIDTH-1:0]  w_shifted;

  // Right shifts fill with the original MSB only in arithmetic mode.
  assign w_fill = (i_mode == MODE_ARITH) ? i_sign : 1'b0;
  assign w_shl  = i_x << S;
  assign w_shr  = WIDTH'({{WIDTH{w_fill}}, i_x} >> S);
  assign w_rotr = WIDTH'({i_x, i_x} >> S);
  assign w_rotl = WIDTH'(({i_x, i_x} << S) >> WIDTH);

  always_comb begin
    w_shifted = i_x;
    if (i_shift[K]) begin
      if (i_mode == MODE_ROTATE) begin
        w_shifted = (i_lr == DIR_LEFT) ? w_rotl : w_rotr;
      end else begin
        w_shifted = (i_lr == DIR_LEFT) ? w_shl : w_shr;
      end
    end
  end

  assign o_load_c = ~r_valid | i_next_load;
  assign o_data_c = w_shifted;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_x     <= '0;
      r_shift <= '0;
      r_lr    <= DIR_LEFT;
      r_mode  <= MODE_LOGICAL;
      r_sign  <= 1'b0;
    end else if (o_load_c) begin
      r_valid <= i_valid;
      r_x     <= w_shifted;
      r_shift <= i_shift;
      r_lr    <= i_lr;
      r_mode  <= i_mode;
      r_sign  <= i_sign;
    end
  end

  assign o_valid = r_valid;
  assign o_x     = r_x;
  assign o_shift = r_shift;
  assign o_lr    = r_lr;
  assign o_mode  = r_mode;
  assign o_sign  = r_sign;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter, one stage per shift-amount bit, valid/ready on both sides.
// Optional registered zero flag on out_zero when BARREL_SHIFT_ZERO_FLAG_EN is defined.
module barrel_shift_pipe
  import barrel_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_x,
  input  logic [SHW-1:0]    in_shift,
  input  logic              in_lr,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_y
`ifdef BARREL_SHIFT_ZERO_FLAG_EN
  ,
  output logic              out_zero
`endif
);

  logic              w_valid [SHW+1];
  logic [WIDTH-1:0]  w_x     [SHW+1];
  logic [SHW-1:0]    w_shift [SHW+1];
  logic              w_lr    [SHW+1];
  logic [MODE_W-1:0] w_mode  [SHW+1];
  logic              w_sign  [SHW+1];
  logic              w_load  [SHW+1];
  logic [WIDTH-1:0]  w_data_c [SHW];

  assign w_valid[0] = in_valid;
  assign w_x[0]     = in_x;
  assign w_shift[0] = in_shift;
  assign w_lr[0]    = in_lr;
  assign w_mode[0]  = in_mode;
  assign w_sign[0]  = in_x[WIDTH-1];
  assign w_load[SHW] = out_ready;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .K     (k)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (w_valid[k]),
      .i_x         (w_x[k]),
      .i_shift     (w_shift[k]),
      .i_lr        (w_lr[k]),
      .i_mode      (w_mode[k]),
      .i_sign      (w_sign[k]),
      .i_next_load (w_load[k+1]),
      .o_load_c    (w_load[k]),
      .o_data_c    (w_data_c[k]),
      .o_valid     (w_valid[k+1]),
      .o_x         (w_x[k+1]),
      .o_shift     (w_shift[k+1]),
      .o_lr        (w_lr[k+1]),
      .o_mode      (w_mode[k+1]),
      .o_sign      (w_sign[k+1])
    );
  end

  // Ready ripples back from out_ready through every stage in the same cycle.
  assign in_ready  = ~rst & w_load[0];
  assign out_valid = w_valid[SHW];
  assign out_y     = w_x[SHW];

  // Per-stage next-data taps and the final stage's command fields have no consumer.
  logic [WIDTH-1:0] w_data_unused;
  logic             w_tail_unused;

  always_comb begin
    w_data_unused = '0;
    for (int k = 0; k < SHW; k++) begin
      w_data_unused = w_data_unused ^ w_data_c[k];
    end
  end

  assign w_tail_unused = ^{w_shift[SHW], w_lr[SHW], w_mode[SHW], w_sign[SHW]};

`ifdef BARREL_SHIFT_ZERO_FLAG_EN
  logic r_zero;

  // Loaded with the same enable and data as out_y so it holds through stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero <= 1'b0;
    end else if (w_load[SHW-1]) begin
      r_zero <= (w_data_c[SHW-1] == '0);
    end
  end

  assign out_zero = r_zero;
`endif

endmodule
